sound_player: RTL and testbench

Downstream consumer of the logo-bounce block's `code_sound`/`mute` outputs. Converts each new sound code into a timed square-wave tone on a single speaker pin: ping, pong or go, then silence. It plays one sound at a time, lets a newer code pre-empt the current one, and gates the pin with `mute` without disturbing sequencing.

---
 rtl/sound_pkg.sv | 20 ++
 rtl/tone_divider.sv | 37 +++
 rtl/sound_player.sv | 140 ++++++++++++++
 tb/tb_sound_player.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound player: sound codes, FSM state encoding and
// the tone half-period helper evaluated at elaboration.
package sound_pkg;

    localparam logic [1:0] SND_STOP = 2'b00;
    localparam logic [1:0] SND_PONG = 2'b01;
    localparam logic [1:0] SND_PING = 2'b10;
    localparam logic [1:0] SND_GO   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned f);
        return clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave tone generator: a half-period down-counter that toggles the tone
// bit and reloads at zero, restarted with the bit cleared on every beep start.
module tone_divider (
    input  logic        clk,
    input  logic        clr,
    input  logic        restart,
    input  logic [23:0] half,
    input  logic        run,
    output logic        tone
);

    logic [23:0] cnt;
    logic        tone_q;
    logic        wrap;

    assign wrap = run && (cnt == 24'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt    <= '0;
            tone_q <= 1'b0;
        end else if (restart) begin
            cnt    <= half - 24'd1;
            tone_q <= 1'b0;
        end else if (wrap) begin
            cnt    <= half - 24'd1;
            tone_q <= ~tone_q;
        end else if (run) begin
            cnt <= cnt - 24'd1;
        end
    end

    // Value the tone bit takes at the coming edge, so the registered speaker
    // output lands on the same edge as the toggle.
    assign tone = restart ? 1'b0 : (tone_q ^ wrap);

endmodule

// File: rtl/sound_player.sv
// Plays ping/pong/go as timed square-wave beeps on one speaker pin; a newer
// code pre-empts the current sound. SOUND_PLAYER_GO_SEQ_EN enables the 3-beep go.
//
// state | meaning
// IDLE  | silent, waiting for a non-stop code change
// TONE  | beep playing for DUR_MS ms
// GAP   | silence between go beeps (only with SOUND_PLAYER_GO_SEQ_EN)
module sound_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned PING_HZ = 880,
    parameter int unsigned PONG_HZ = 440,
    parameter int unsigned GO_HZ   = 660,
    parameter int unsigned DUR_MS  = 100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] code_sound,
    input  logic       mute,
    output logic       speaker,
    output logic       busy
);

    localparam logic [23:0] HALF_PING = 24'(half_period(CLK_HZ, PING_HZ));
    localparam logic [23:0] HALF_PONG = 24'(half_period(CLK_HZ, PONG_HZ));
    localparam logic [23:0] HALF_GO   = 24'(half_period(CLK_HZ, GO_HZ));
    localparam logic [23:0] PRE_LAST  = 24'(CLK_HZ / 1000 - 1);
    localparam logic [15:0] DUR_LAST  = 16'(DUR_MS - 1);

    state_t      state, state_nxt;
    logic [1:0]  code_prev, code_cur, code_sel;
    logic [23:0] presc;
    logic [15:0] ms_cnt;
    logic [23:0] half;
    logic        trig, tick, dur_done, entry, restart, tone;
`ifdef SOUND_PLAYER_GO_SEQ_EN
    logic [1:0]  beeps_left;
`endif

    assign trig     = (code_sound != code_prev);
    assign tick     = (presc == PRE_LAST);
    assign dur_done = tick && (ms_cnt == DUR_LAST);
    assign entry    = trig || (state_nxt != state);
    assign busy     = (state != IDLE);

    // The divider reloads on the trigger edge, before code_cur has caught up.
    assign code_sel = trig ? code_sound : code_cur;

    always_comb begin
        half = HALF_GO;
        case (code_sel)
            SND_PONG: half = HALF_PONG;
            SND_PING: half = HALF_PING;
            default:  half = HALF_GO;
        endcase
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        if (trig) begin
            if (code_sound == SND_STOP) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = TONE;
                restart   = 1'b1;
            end
        end else begin
            case (state)
                TONE: begin
                    if (dur_done) begin
`ifdef SOUND_PLAYER_GO_SEQ_EN
                        state_nxt = (beeps_left == 2'd0) ? IDLE : GAP;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
`ifdef SOUND_PLAYER_GO_SEQ_EN
                GAP: begin
                    if (dur_done) begin
                        state_nxt = TONE;
                        restart   = 1'b1;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            code_prev <= SND_STOP;
            code_cur  <= SND_STOP;
            presc     <= '0;
            ms_cnt    <= '0;
            speaker   <= 1'b0;
        end else begin
            state     <= state_nxt;
            code_prev <= code_sound;
            if (trig && (code_sound != SND_STOP))
                code_cur <= code_sound;
            // A tick coinciding with a state entry is dropped by the clear.
            if (entry || (state == IDLE)) begin
                presc  <= '0;
                ms_cnt <= '0;
            end else if (tick) begin
                presc  <= '0;
                ms_cnt <= ms_cnt + 16'd1;
            end else begin
                presc <= presc + 24'd1;
            end
            speaker <= tone && (state_nxt == TONE) && !mute;
        end
    end

`ifdef SOUND_PLAYER_GO_SEQ_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            beeps_left <= 2'd0;
        else if (trig && (code_sound != SND_STOP))
            beeps_left <= (code_sound == SND_GO) ? 2'd2 : 2'd0;
        else if ((state == GAP) && dur_done)
            beeps_left <= beeps_left - 2'd1;
    end
`endif

    tone_divider u_tone_divider (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .half    (half),
        .run     (state == TONE),
        .tone    (tone)
    );

endmodule

// File: tb/tb_sound_player.sv
// Self-checking bench for sound_player: directed scenarios plus random code and
// mute traffic, compared every cycle against an elapsed-time reference model.
module tb_sound_player;

    logic       clk = 1'b0;
    logic       clr;
    logic       mute;
    logic [1:0] code_sound;
    logic       speaker;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Reference model: time since the last sound started, plus the sound code.
    logic [1:0] m_prev;
    logic [1:0] m_code;
    bit         m_active;
    int         m_k;
    logic       exp_spk;
    logic       exp_busy;

    int   busy_cnt;
    int   rises;
    int   first_rise;
    logic spk_last;

    localparam int SEG = 200;
`ifdef SOUND_PLAYER_GO_SEQ_EN
    localparam int GO_LEN   = 1000;
    localparam int GO_RISES = 12;
`else
    localparam int GO_LEN   = 200;
    localparam int GO_RISES = 4;
`endif

    sound_player #(
        .CLK_HZ  (100_000),
        .PING_HZ (1000),
        .PONG_HZ (500),
        .GO_HZ   (2000),
        .DUR_MS  (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .code_sound (code_sound),
        .mute       (mute),
        .speaker    (speaker),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic int half_of(input logic [1:0] c);
        case (c)
            2'b01:   return 100;
            2'b10:   return 50;
            default: return 25;
        endcase
    endfunction

    function automatic int len_of(input logic [1:0] c);
        return (c == 2'b11) ? GO_LEN : SEG;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_prev   = 2'b00;
        m_code   = 2'b00;
        m_active = 1'b0;
        m_k      = 0;
        exp_spk  = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic model_edge();
        if (!clr) begin
            model_reset();
        end else begin
            if (code_sound != m_prev) begin
                if (code_sound != 2'b00) begin
                    m_active = 1'b1;
                    m_code   = code_sound;
                    m_k      = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                m_k++;
                if (m_k >= len_of(m_code))
                    m_active = 1'b0;
            end
            m_prev   = code_sound;
            exp_busy = m_active;
            exp_spk  = m_active && ((m_k / SEG) % 2 == 0)
                       && (((m_k % SEG) / half_of(m_code)) % 2 == 1) && !mute;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_bit("speaker", speaker, exp_spk);
        check_bit("busy", busy, exp_busy);
    endtask

    task automatic run(input int n);
        for (int i = 1; i <= n; i++) begin
            step();
            if (busy)
                busy_cnt++;
            if (speaker && !spk_last) begin
                rises++;
                if (first_rise < 0)
                    first_rise = i;
            end
            spk_last = speaker;
        end
    endtask

    task automatic clear_stats();
        busy_cnt   = 0;
        rises      = 0;
        first_rise = -1;
        spk_last   = speaker;
    endtask

    initial begin
        clr        = 1'b0;
        mute       = 1'b0;
        code_sound = 2'b00;
        model_reset();
        #3;
        check_bit("reset_speaker", speaker, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        #9;
        clr = 1'b1;
        run(5);

        // Ping, single beep
        clear_stats();
        code_sound = 2'b10;
        run(260);
        check_int("ping_busy_cycles", busy_cnt, 200);
        check_int("ping_first_rise", first_rise, 51);
        check_int("ping_rises", rises, 2);

        // Go
        code_sound = 2'b00;
        run(5);
        clear_stats();
        code_sound = 2'b11;
        run(1100);
        check_int("go_busy_cycles", busy_cnt, GO_LEN);
        check_int("go_rises", rises, GO_RISES);

        // Pre-emption: ping then pong 60 cycles later
        code_sound = 2'b00;
        run(5);
        code_sound = 2'b10;
        run(60);
        clear_stats();
        code_sound = 2'b01;
        run(260);
        check_int("preempt_busy_cycles", busy_cnt, 200);
        check_int("preempt_first_rise", first_rise, 101);

        // Abort mid-tone, then a held code must not retrigger
        code_sound = 2'b00;
        run(5);
        code_sound = 2'b10;
        run(80);
        code_sound = 2'b00;
        run(2);
        check_bit("abort_speaker", speaker, 1'b0);
        check_bit("abort_busy", busy, 1'b0);
        clear_stats();
        code_sound = 2'b10;
        run(1000);
        check_int("hold_busy_cycles", busy_cnt, 200);

        // Mute the middle 100 cycles of a ping
        code_sound = 2'b00;
        run(5);
        clear_stats();
        code_sound = 2'b10;
        run(50);
        mute = 1'b1;
        run(100);
        mute = 1'b0;
        run(110);
        check_int("mute_busy_cycles", busy_cnt, 200);
        check_int("mute_rises", rises, 1);

        // Asynchronous reset mid-pong, release with pong held
        code_sound = 2'b00;
        run(5);
        code_sound = 2'b01;
        run(80);
        #2;
        clr = 1'b0;
        #1;
        check_bit("async_rst_speaker", speaker, 1'b0);
        check_bit("async_rst_busy", busy, 1'b0);
        model_reset();
        run(3);
        clr = 1'b1;
        clear_stats();
        run(260);
        check_int("rst_retrigger_busy", busy_cnt, 200);
        check_int("rst_retrigger_first_rise", first_rise, 101);

        // Random code changes and mute toggles
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0)
                code_sound = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0)
                mute = ~mute;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
